// File: rtl/pic_nch_pkg.sv
// Shared types, default sizing and helpers for the pic_nch interrupt controller.
package pic_nch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int DEF_NCH  = 9;
  localparam int DEF_NLVL = 3;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_nch_prienc.sv
// Parametric first-set finder: valid when any request is set, idx is the lowest set position.
module pic_nch_prienc #(
  parameter int WIDTH = 8,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/pic_nch.sv
// Multi-level priority interrupt controller with pending latches, request/ack handshake and nested ISR.
// Build option: define PIC_NCH_LEVEL_EN for level-sensitive pending (no edge latch).
module pic_nch
  import pic_nch_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int NLVL = DEF_NLVL,
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW  = (NLVL > 1) ? $clog2(NLVL) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NLVL*NCH-1:0] irq_i,
  input  logic [NCH-1:0]      en_i,
  input  logic                ack_i,
  input  logic                eoi_i,
  output logic                int_o,
  output logic [LW-1:0]       int_lvl_o,
  output logic [IDW-1:0]      int_id_o,
  output logic [NLVL-1:0]     isr_o,
  output logic                state_dbg
);

  // Handshake: int_o rises with int_lvl_o/int_id_o latched and holds them unchanged
  // until the cycle ack_i is sampled high; ack_i while int_o is low has no effect.
  state_t              state, state_nxt;
  logic [NLVL*NCH-1:0] pend;
  logic [NLVL-1:0]     isr, isr_nxt, allowed, lvl_valid;
  logic [IDW-1:0]      lvl_idx [NLVL];
  logic                any_elig;
  logic [LW-1:0]       win_lvl;
  logic [IDW-1:0]      win_id;
  logic                take, ack_take;
  int                  eoi_idx;

  assign take     = (state == IDLE) && any_elig;
  assign ack_take = (state == REQ) && ack_i;

`ifdef PIC_NCH_LEVEL_EN
  assign pend = irq_i;
`else
  logic [NLVL*NCH-1:0] irq_q;
  logic [NLVL*NCH-1:0] ack_clr;

  always_comb begin
    ack_clr = '0;
    for (int l = 0; l < NLVL; l++) begin
      for (int c = 0; c < NCH; c++) begin
        ack_clr[l*NCH+c] = ack_take && (int_lvl_o == LW'(l)) && (int_id_o == IDW'(c));
      end
    end
  end

  // A fresh edge in the same cycle as its ack keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq_i;
      pend  <= (pend & ~ack_clr) | (irq_i & ~irq_q);
    end
  end
`endif

  // A level may preempt only if it is strictly above every in-service level.
  always_comb begin
    logic blk;
    blk = 1'b0;
    for (int l = 0; l < NLVL; l++) begin
      blk        = blk | isr[l];
      allowed[l] = ~blk;
    end
  end

  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    pic_nch_prienc #(.WIDTH(NCH), .IW(IDW)) u_enc (
      .req   (pend[l*NCH +: NCH] & en_i & {NCH{allowed[l]}}),
      .valid (lvl_valid[l]),
      .idx   (lvl_idx[l])
    );
  end

  pic_nch_prienc #(.WIDTH(NLVL), .IW(LW)) u_lvl (
    .req   (lvl_valid),
    .valid (any_elig),
    .idx   (win_lvl)
  );

  always_comb begin
    win_id = '0;
    for (int l = 0; l < NLVL; l++) begin
      if (win_lvl == LW'(l)) win_id = lvl_idx[l];
    end
  end

  // eoi works on the in-service set as it stood at cycle start; ack then adds its level.
  always_comb begin
    eoi_idx = lowest_set(32'(isr));
    isr_nxt = isr;
    for (int l = 0; l < NLVL; l++) begin
      if (eoi_i && (isr != '0) && (l == eoi_idx)) isr_nxt[l] = 1'b0;
      if (ack_take && (int_lvl_o == LW'(l))) isr_nxt[l] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = REQ;
      REQ:     if (ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      isr       <= '0;
      int_o     <= 1'b0;
      int_lvl_o <= '0;
      int_id_o  <= '0;
    end else begin
      state <= state_nxt;
      isr   <= isr_nxt;
      if (take) begin
        int_o     <= 1'b1;
        int_lvl_o <= win_lvl;
        int_id_o  <= win_id;
      end else if (ack_take) begin
        int_o <= 1'b0;
      end
    end
  end

  assign isr_o     = isr;
  assign state_dbg = state;

endmodule

// File: tb/tb_pic_nch.sv
// Directed bench for pic_nch (NCH=9, NLVL=3): vector table plus hand sequences for reset and ack/edge races.
module tb_pic_nch;

  localparam logic [8:0] ALL = 9'h1FF;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] irq_i;
  logic [8:0]  en_i;
  logic        ack_i, eoi_i;
  logic        int_o;
  logic [1:0]  int_lvl_o;
  logic [3:0]  int_id_o;
  logic [2:0]  isr_o;
  logic        state_dbg;

  int errors = 0;
  int checks = 0;

  pic_nch #(.NCH(9), .NLVL(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (irq_i),
    .en_i      (en_i),
    .ack_i     (ack_i),
    .eoi_i     (eoi_i),
    .int_o     (int_o),
    .int_lvl_o (int_lvl_o),
    .int_id_o  (int_id_o),
    .isr_o     (isr_o),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] irq;
    logic [8:0]  en;
    logic        ack;
    logic        eoi;
    logic        e_int;
    logic [1:0]  e_lvl;
    logic [3:0]  e_id;
    logic [2:0]  e_isr;
  } vec_t;

  vec_t tv[$];

  function automatic logic [26:0] b(input int i);
    logic [26:0] one;
    one = 27'd1;
    return one << i;
  endfunction

  function automatic void add(input logic [26:0] irq, input logic [8:0] en, input logic ack,
                              input logic eoi, input logic e_int, input logic [1:0] e_lvl,
                              input logic [3:0] e_id, input logic [2:0] e_isr);
    vec_t v;
    v.irq = irq; v.en = en; v.ack = ack; v.eoi = eoi;
    v.e_int = e_int; v.e_lvl = e_lvl; v.e_id = e_id; v.e_isr = e_isr;
    tv.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic [26:0] irq, input logic [8:0] en, input logic ack,
                     input logic eoi, input logic r);
    irq_i = irq; en_i = en; ack_i = ack; eoi_i = eoi; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input logic e_int, input logic [1:0] lvl,
                         input logic [3:0] id);
    check({nm, " int"}, 32'(int_o), 32'(e_int));
    if (e_int) begin
      check({nm, " lvl"}, 32'(int_lvl_o), 32'(lvl));
      check({nm, " id"}, 32'(int_id_o), 32'(id));
    end
  endtask

  initial begin
    cyc('0, ALL, 0, 0, 1);
    cyc('0, ALL, 0, 0, 1);
    check("reset int", 32'(int_o), 0);
    check("reset lvl", 32'(int_lvl_o), 0);
    check("reset id", 32'(int_id_o), 0);
    check("reset isr", 32'(isr_o), 0);
    check("reset state", 32'(state_dbg), 0);

`ifndef PIC_NCH_LEVEL_EN
    // single request, +2 latency, ack, eoi
    add(b(4), ALL, 0, 0, 0, 0, 0, 3'b000);
    add('0,   ALL, 0, 0, 1, 0, 4, 3'b000);
    add('0,   ALL, 1, 0, 0, 0, 0, 3'b001);
    add('0,   ALL, 0, 1, 0, 0, 0, 3'b000);
    // simultaneous L2C1, L1C7, L1C3
    add(b(19) | b(16) | b(12), ALL, 0, 0, 0, 0, 0, 3'b000);
    add('0, ALL, 0, 0, 1, 1, 3, 3'b000);
    add('0, ALL, 1, 0, 0, 0, 0, 3'b010);
    add('0, ALL, 0, 0, 0, 0, 0, 3'b010);
    add('0, ALL, 0, 1, 0, 0, 0, 3'b000);
    add('0, ALL, 0, 0, 1, 1, 7, 3'b000);
    add('0, ALL, 1, 0, 0, 0, 0, 3'b010);
    add('0, ALL, 0, 1, 0, 0, 0, 3'b000);
    add('0, ALL, 0, 0, 1, 2, 1, 3'b000);
    add('0, ALL, 1, 0, 0, 0, 0, 3'b100);
    add('0, ALL, 0, 1, 0, 0, 0, 3'b000);
    add('0, ALL, 0, 0, 0, 0, 0, 3'b000);
    // nesting L2C0 then L0C8
    add(b(18), ALL, 0, 0, 0, 0, 0, 3'b000);
    add('0,    ALL, 0, 0, 1, 2, 0, 3'b000);
    add('0,    ALL, 1, 0, 0, 0, 0, 3'b100);
    add(b(8),  ALL, 0, 0, 0, 0, 0, 3'b100);
    add('0,    ALL, 0, 0, 1, 0, 8, 3'b100);
    add('0,    ALL, 1, 0, 0, 0, 0, 3'b101);
    add('0,    ALL, 0, 1, 0, 0, 0, 3'b100);
    add('0,    ALL, 0, 1, 0, 0, 0, 3'b000);
    add('0,    ALL, 0, 0, 0, 0, 0, 3'b000);
    // channel enable gating, idle ack and empty eoi ignored
    add(b(5), 9'h1DF, 0, 0, 0, 0, 0, 3'b000);
    add('0,   9'h1DF, 0, 0, 0, 0, 0, 3'b000);
    add('0,   9'h1DF, 0, 0, 0, 0, 0, 3'b000);
    add('0,   ALL,    0, 0, 1, 0, 5, 3'b000);
    add('0,   ALL,    1, 0, 0, 0, 0, 3'b001);
    add('0,   ALL,    0, 1, 0, 0, 0, 3'b000);
    add('0,   ALL,    1, 0, 0, 0, 0, 3'b000);
    add('0,   ALL,    0, 1, 0, 0, 0, 3'b000);
    // frozen request, then same-cycle ack+eoi
    add(b(20), ALL,   0, 0, 0, 0, 0, 3'b000);
    add('0,    ALL,   0, 0, 1, 2, 2, 3'b000);
    add(b(0),  ALL,   0, 0, 1, 2, 2, 3'b000);
    add('0,    9'h0,  0, 0, 1, 2, 2, 3'b000);
    add('0,    ALL,   1, 0, 0, 0, 0, 3'b100);
    add('0,    ALL,   0, 0, 1, 0, 0, 3'b100);
    add('0,    ALL,   1, 1, 0, 0, 0, 3'b001);
    add('0,    ALL,   0, 1, 0, 0, 0, 3'b000);
    add('0,    ALL,   0, 0, 0, 0, 0, 3'b000);

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].irq, tv[i].en, tv[i].ack, tv[i].eoi, 0);
      chk_int($sformatf("row%0d", i), tv[i].e_int, tv[i].e_lvl, tv[i].e_id);
      check($sformatf("row%0d isr", i), 32'(isr_o), 32'(tv[i].e_isr));
    end

    // reset while presenting with three bits pending and isr nonzero
    cyc(b(18), ALL, 0, 0, 0);
    cyc('0, ALL, 0, 0, 0);
    cyc('0, ALL, 1, 0, 0);
    check("rstseq isr", 32'(isr_o), 32'(3'b100));
    cyc(b(1) | b(10) | b(20), ALL, 0, 0, 0);
    cyc('0, ALL, 0, 0, 0);
    chk_int("rstseq pre", 1, 0, 1);
    cyc(b(3), ALL, 0, 0, 1);
    check("rstseq int", 32'(int_o), 0);
    check("rstseq isr0", 32'(isr_o), 0);
    check("rstseq lvl", 32'(int_lvl_o), 0);
    check("rstseq id", 32'(int_id_o), 0);
    for (int i = 0; i < 4; i++) begin
      cyc('0, ALL, 0, 0, 0);
      check($sformatf("rstseq quiet%0d", i), 32'(int_o), 0);
    end

    // ack of L0C2 coincides with a fresh edge on L0C2
    cyc(b(2), ALL, 0, 0, 0);
    cyc('0, ALL, 0, 0, 0);
    chk_int("race pres", 1, 0, 2);
    cyc(b(2), ALL, 1, 0, 0);
    check("race ack int", 32'(int_o), 0);
    check("race ack isr", 32'(isr_o), 32'(3'b001));
    cyc('0, ALL, 0, 0, 0);
    check("race blocked", 32'(int_o), 0);
    cyc('0, ALL, 0, 1, 0);
    check("race eoi isr", 32'(isr_o), 0);
    cyc('0, ALL, 0, 0, 0);
    chk_int("race repres", 1, 0, 2);
    cyc('0, ALL, 1, 0, 0);
    cyc('0, ALL, 0, 1, 0);
    cyc('0, ALL, 0, 0, 0);
    check("race drained", 32'(int_o), 0);
    check("race isr end", 32'(isr_o), 0);
`else
    // held line re-requests after eoi without a new edge
    cyc(b(2), ALL, 0, 0, 0);
    chk_int("lvl pres", 1, 0, 2);
    cyc(b(2), ALL, 1, 0, 0);
    check("lvl ack int", 32'(int_o), 0);
    check("lvl ack isr", 32'(isr_o), 32'(3'b001));
    cyc(b(2), ALL, 0, 0, 0);
    check("lvl blocked", 32'(int_o), 0);
    cyc(b(2), ALL, 0, 1, 0);
    check("lvl eoi isr", 32'(isr_o), 0);
    cyc(b(2), ALL, 0, 0, 0);
    chk_int("lvl repres", 1, 0, 2);
    cyc('0, ALL, 1, 0, 0);
    check("lvl ack2 isr", 32'(isr_o), 32'(3'b001));
    cyc('0, ALL, 0, 1, 0);
    cyc('0, ALL, 0, 0, 0);
    check("lvl drained", 32'(int_o), 0);
    check("lvl isr end", 32'(isr_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
